// File: rtl/ins_queue_pkg.sv
// Shared widths and entry layout for the instruction queue.
// Optional build macro: INSQ_BYPASS_EN (same-cycle push-to-issue path when empty).
package ins_queue_pkg;

  localparam int INS_LEN  = 32;
  localparam int PC_LEN   = 32;
  localparam int INSQ_LEN = 4;
  localparam int INSQ_SIZ = 1 << INSQ_LEN;

  typedef struct packed {
    logic [INS_LEN-1:0] ins;
    logic [PC_LEN-1:0]  pc;
    logic [PC_LEN-1:0]  pred_pc;
  } insq_entry_t;

  function automatic insq_entry_t make_entry(input logic [INS_LEN-1:0] ins,
                                             input logic [PC_LEN-1:0]  pc,
                                             input logic [PC_LEN-1:0]  pred_pc);
    insq_entry_t e;
    e.ins     = ins;
    e.pc      = pc;
    e.pred_pc = pred_pc;
    return e;
  endfunction

endpackage

// File: rtl/ins_queue.sv
// Circular instruction queue between fetch and issue, show-ahead head, flush on jump.
// Build macro INSQ_BYPASS_EN adds a same-cycle push-to-issue path when the queue is empty.
module ins_queue
  import ins_queue_pkg::*;
#(
  parameter int DEPTH_LOG = INSQ_LEN
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ready,
  input  logic                 push,
  input  logic [INS_LEN-1:0]   push_ins,
  input  logic [PC_LEN-1:0]    push_pc,
  input  logic [PC_LEN-1:0]    push_pred_pc,
  output logic                 insq_full,
  output logic                 issue_valid,
  output logic [INS_LEN-1:0]   issue_ins,
  output logic [PC_LEN-1:0]    issue_pc,
  output logic [PC_LEN-1:0]    issue_pred_pc,
  input  logic                 issue_ready,
  input  logic                 jump,
  output logic [DEPTH_LOG-1:0] dbg_head,
  output logic [DEPTH_LOG-1:0] dbg_tail,
  output logic [DEPTH_LOG:0]   dbg_count
);

  // Handshake: an entry leaves when issue_valid && issue_ready at a rising edge
  // with ready=1 and jump=0; push is a one-sided write qualified only by room.

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] CNT_MAX  = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] CNT_FULL = (DEPTH_LOG+1)'(DEPTH - 1);

  insq_entry_t          mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] head_q, head_d;
  logic [DEPTH_LOG-1:0] tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 empty;
  logic                 bypass_take;
  logic                 do_pop;
  logic                 do_push;
  logic                 wr_en;
  insq_entry_t          head_entry;
  insq_entry_t          push_entry;
  insq_entry_t          issue_entry;

  assign empty      = (count_q == '0);
  assign head_entry = mem_q[head_q];
  assign push_entry = make_entry(push_ins, push_pc, push_pred_pc);

  // Fetch registers push a cycle after seeing insq_full, so one slot stays spare.
  assign insq_full = (count_q >= CNT_FULL);

`ifdef INSQ_BYPASS_EN
  logic bypass_act;
  assign bypass_act  = ready & push & ~jump & empty;
  assign bypass_take = bypass_act & issue_ready;
  assign issue_valid = ~empty | bypass_act;
  assign issue_entry = bypass_act ? push_entry : head_entry;
`else
  assign bypass_take = 1'b0;
  assign issue_valid = ~empty;
  assign issue_entry = head_entry;
`endif

  assign issue_ins     = issue_entry.ins;
  assign issue_pc      = issue_entry.pc;
  assign issue_pred_pc = issue_entry.pred_pc;

  always_comb begin
    do_pop  = ~empty & issue_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    do_push = push & ((count_q != CNT_MAX) | do_pop) & ~bypass_take;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr_en   = 1'b0;
    if (ready) begin
      if (jump) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (do_pop) begin
          head_d = head_q + DEPTH_LOG'(1);
        end
        if (do_push) begin
          tail_d = tail_q + DEPTH_LOG'(1);
          wr_en  = 1'b1;
        end
        case ({do_push, do_pop})
          2'b10:   count_d = count_q + (DEPTH_LOG+1)'(1);
          2'b01:   count_d = count_q - (DEPTH_LOG+1)'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately unreset; issue_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[tail_q] <= push_entry;
    end
  end

  assign dbg_head  = head_q;
  assign dbg_tail  = tail_q;
  assign dbg_count = count_q;

endmodule
